// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset controller. Waits for PLL lock, holds
// all domains for POR_CYCLES, then releases NUM_DOMAINS resets in index
// order STAGGER_CYCLES apart. Re-enters reset on PLL loss, a debounced
// button press or a software request; records the cause and counts events.
// Ports:
//   clk, reset_i (async active-high)      clock and master reset
//   pll_locked_i, btn_i (asynchronous)    lock indication, raw button
//   sw_reset_req_i                        software reset request
//   reset_o[NUM_DOMAINS], ready_o         per-domain resets, all-released
//   reset_cause_o[2], reset_count_o[8]    last cause, saturating event count
module reset_sequencer #(
   parameter int NUM_DOMAINS     = 2,
   parameter int POR_CYCLES      = 31,
   parameter int STAGGER_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset_i,
   input  logic                   pll_locked_i,
   input  logic                   btn_i,
   input  logic                   sw_reset_req_i,
   output logic [NUM_DOMAINS-1:0] reset_o,
   output logic                   ready_o,
   output logic [1:0]             reset_cause_o,
   output logic [7:0]             reset_count_o
);

   localparam int PW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
   localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [PW-1:0] POR_MAX = PW'(POR_CYCLES - 1);
   localparam logic [SW-1:0] STG_MAX = SW'(STAGGER_CYCLES - 1);
   localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

   localparam logic [NUM_DOMAINS-1:0] ALL_ON = {NUM_DOMAINS{1'b1}};
   // Pattern after domain 0 is released; all zero when NUM_DOMAINS == 1.
   localparam logic [NUM_DOMAINS-1:0] FIRST  = ALL_ON << 1;

   localparam logic [1:0] S_WAIT = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_REL  = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   localparam logic [1:0] C_POR = 2'd0;
   localparam logic [1:0] C_PLL = 2'd1;
   localparam logic [1:0] C_BTN = 2'd2;
   localparam logic [1:0] C_SW  = 2'd3;

   logic [1:0]             state;
   logic                   lock_s1, lock_s2;
   logic                   btn_s1, btn_s2;
   logic                   btn_n, btn_db;
   logic [DW-1:0]          db_cnt;
   logic                   sw_prev;
   logic [PW-1:0]          hc;
   logic [SW-1:0]          sc;
   logic [NUM_DOMAINS-1:0] rel_next;
   logic                   db_rise, trig_pll, trig_btn, trig_sw;
   logic                   trig_any, active;
   logic [1:0]             trig_cause;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
         sw_prev <= 1'b0;
      end else begin
         lock_s1 <= pll_locked_i;
         lock_s2 <= lock_s1;
         btn_s1  <= btn_i;
         btn_s2  <= btn_s1;
         sw_prev <= sw_reset_req_i;
      end
   end

   assign btn_n = BTN_ACTIVE_HIGH ? btn_s2 : ~btn_s2;

   // Counter only runs while the synced value differs from the debounced
   // one; any bounce back to the debounced value reloads it.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         btn_db <= 1'b0;
         db_cnt <= '0;
      end else if (btn_n == btn_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
         btn_db <= btn_n;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DW'(1);
      end
   end

   // Press is flagged on the cycle the debounced value is about to rise,
   // so the reset lands on the same edge as the debounced update.
   assign db_rise  = btn_n & ~btn_db & (db_cnt == DB_MAX);
   // Lock and button were both good on HOLD entry, so a low level here
   // is necessarily a falling edge.
   assign trig_pll = ~lock_s2;
   assign trig_btn = db_rise;
   assign trig_sw  = sw_reset_req_i & ~sw_prev;
   assign trig_any = trig_pll | trig_btn | trig_sw;
   assign active   = (state != S_WAIT);

   assign trig_cause = trig_pll ? C_PLL :
                       trig_btn ? C_BTN : C_SW;

   assign rel_next = reset_o << 1;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state         <= S_WAIT;
         reset_o       <= ALL_ON;
         ready_o       <= 1'b0;
         reset_cause_o <= C_POR;
         reset_count_o <= 8'd0;
         hc            <= '0;
         sc            <= '0;
      end else if (active && trig_any) begin
         state         <= S_WAIT;
         reset_o       <= ALL_ON;
         ready_o       <= 1'b0;
         reset_cause_o <= trig_cause;
         if (reset_count_o != 8'hFF)
            reset_count_o <= reset_count_o + 8'd1;
      end else begin
         unique case (state)
            S_WAIT: begin
               reset_o <= ALL_ON;
               ready_o <= 1'b0;
               if (lock_s2 && !btn_db) begin
                  state <= S_HOLD;
                  hc    <= '0;
               end
            end
            S_HOLD: begin
               if (hc == POR_MAX) begin
                  reset_o <= FIRST;
                  hc      <= '0;
                  sc      <= '0;
                  if (FIRST == '0) begin
                     ready_o <= 1'b1;
                     state   <= S_RUN;
                  end else begin
                     state   <= S_REL;
                  end
               end else begin
                  hc <= hc + PW'(1);
               end
            end
            S_REL: begin
               if (sc == STG_MAX) begin
                  sc      <= '0;
                  reset_o <= rel_next;
                  if (rel_next == '0) begin
                     ready_o <= 1'b1;
                     state   <= S_RUN;
                  end
               end else begin
                  sc <= sc + SW'(1);
               end
            end
            S_RUN: begin
               reset_o <= '0;
               ready_o <= 1'b1;
            end
            default: state <= S_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer with
// NUM_DOMAINS=3, POR=8, STAGGER=4, DEBOUNCE=16.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       pll;
   logic       btn;
   logic       sw;
   logic [2:0] reset_o;
   logic       ready_o;
   logic [1:0] cause;
   logic [7:0] count;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .NUM_DOMAINS(3),
      .POR_CYCLES(8),
      .STAGGER_CYCLES(4),
      .DEBOUNCE_CYCLES(16),
      .BTN_ACTIVE_HIGH(1'b1)
   ) dut (
      .clk(clk),
      .reset_i(reset_i),
      .pll_locked_i(pll),
      .btn_i(btn),
      .sw_reset_req_i(sw),
      .reset_o(reset_o),
      .ready_o(ready_o),
      .reset_cause_o(cause),
      .reset_count_o(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       lock;
      logic       sw;
      int         n;
      logic [2:0] rst;
      logic       rdy;
      logic [1:0] cause;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act,
                              input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic check_outs(input string name, input int r, input int rd,
                             input int c, input int n);
      check({name, "_rst"}, int'(reset_o), r);
      check({name, "_rdy"}, int'(ready_o), rd);
      check({name, "_cause"}, int'(cause), c);
      check({name, "_cnt"}, int'(count), n);
   endtask

   // Cycle numbers below count clock edges after the call.
   task automatic measure_release(input string name, input int exp0);
      int f0 = -1;
      int f1 = -1;
      int f2 = -1;
      int fr = -1;
      for (int n = 1; n <= 60 && fr < 0; n++) begin
         tick();
         if (f0 < 0 && !reset_o[0]) f0 = n;
         if (f1 < 0 && !reset_o[1]) f1 = n;
         if (f2 < 0 && !reset_o[2]) f2 = n;
         if (fr < 0 && ready_o) fr = n;
      end
      check({name, "_d0"}, f0, exp0);
      check({name, "_d1"}, f1, exp0 + 4);
      check({name, "_d2"}, f2, exp0 + 8);
      check({name, "_rdy"}, fr, exp0 + 8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int fa;
      int bad;
      int exp_cnt;
      int seen;

      tbl[0]  = '{1'b1, 1'b1, 1, 3'b111, 1'b0, 2'd3, 8'd3};
      tbl[1]  = '{1'b1, 1'b0, 9, 3'b110, 1'b0, 2'd3, 8'd3};
      tbl[2]  = '{1'b1, 1'b0, 8, 3'b000, 1'b1, 2'd3, 8'd3};
      tbl[3]  = '{1'b1, 1'b1, 1, 3'b111, 1'b0, 2'd3, 8'd4};
      tbl[4]  = '{1'b1, 1'b1, 4, 3'b111, 1'b0, 2'd3, 8'd4};
      tbl[5]  = '{1'b1, 1'b0, 5, 3'b110, 1'b0, 2'd3, 8'd4};
      tbl[6]  = '{1'b1, 1'b0, 8, 3'b000, 1'b1, 2'd3, 8'd4};
      // Lock drop: sw is raised when the loss reaches the synchroniser
      // output so both triggers hit the same edge.
      tbl[7]  = '{1'b0, 1'b0, 2, 3'b000, 1'b1, 2'd3, 8'd4};
      tbl[8]  = '{1'b0, 1'b1, 1, 3'b111, 1'b0, 2'd1, 8'd5};
      tbl[9]  = '{1'b0, 1'b0, 5, 3'b111, 1'b0, 2'd1, 8'd5};
      tbl[10] = '{1'b1, 1'b0, 10, 3'b111, 1'b0, 2'd1, 8'd5};
      tbl[11] = '{1'b1, 1'b0, 1, 3'b110, 1'b0, 2'd1, 8'd5};
      tbl[12] = '{1'b1, 1'b0, 8, 3'b000, 1'b1, 2'd1, 8'd5};

      reset_i = 1'b1;
      pll     = 1'b1;
      btn     = 1'b0;
      sw      = 1'b0;
      repeat (3) tick();
      check_outs("por", 7, 0, 0, 0);

      // Power-on release: HOLD on edge 3, domains at 11/15/19.
      reset_i = 1'b0;
      measure_release("por_rel", 11);
      check_outs("por_run", 0, 1, 0, 0);

      // PLL loss.
      pll = 1'b0;
      tick();
      tick();
      check("pll_sync_delay", int'(reset_o), 0);
      tick();
      check_outs("pll_loss", 7, 0, 1, 1);
      repeat (7) tick();
      pll = 1'b1;
      measure_release("pll_rel", 11);

      // Bouncing button must not trigger.
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         btn = ((i / 3) % 2 == 0);
         tick();
         if (reset_o != 3'b000) bad++;
      end
      check("bounce_quiet", bad, 0);
      btn = 1'b1;
      fa = -1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (fa < 0 && reset_o != 3'b000) fa = n;
      end
      check_range("btn_assert", fa, 18, 19);
      check_outs("btn_evt", 7, 0, 2, 2);
      btn = 1'b0;
      measure_release("btn_rel", 27);

      for (int i = 0; i < 13; i++) begin
         pll = tbl[i].lock;
         sw  = tbl[i].sw;
         repeat (tbl[i].n) tick();
         check_outs($sformatf("v%0d", i), int'(tbl[i].rst),
                    int'(tbl[i].rdy), int'(tbl[i].cause),
                    int'(tbl[i].cnt));
      end

      // Saturation: each pulse lands in HOLD after the previous one.
      exp_cnt = 5;
      for (int i = 0; i < 300; i++) begin
         sw = 1'b1;
         tick();
         sw = 1'b0;
         tick();
         if (exp_cnt < 255) exp_cnt++;
         if (i == 248) check("sat_254", int'(count), exp_cnt);
      end
      check("sat_255", int'(count), exp_cnt);
      check("sat_cause", int'(cause), 3);

      // Async reset_i while domain 0 is already released.
      seen = 0;
      for (int n = 0; n < 100 && seen == 0; n++) begin
         tick();
         if (reset_o == 3'b110) seen = 1;
      end
      check("rel_reached", seen, 1);
      #2;
      reset_i = 1'b1;
      #1;
      check_outs("async_rst", 7, 0, 0, 0);
      tick();
      reset_i = 1'b0;
      measure_release("post_rst", 11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
